// File: rtl/register_bank_16_pkg.sv
// Shared definitions for the 16-entry register bank: sizes, select type and
// the one-hot check used to qualify writes.
package regbank_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef logic [NUM_REGS-1:0] wsel_t;

  // True when exactly one select bit is set; zero or multiple bits are malformed.
  function automatic logic onehot16_valid(input wsel_t sel);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, sel[i]};
    end
    return (cnt == {{ADDR_W{1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/register_bank_16_if.sv
// Write/read bus of the register bank; the datapath side drives it as master,
// the bank consumes it as slave.
interface register_bank_16_if
  import regbank_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic              WriteEnable;
  wsel_t             WriteSelect;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadAddrA;
  logic [ADDR_W-1:0] ReadAddrB;
  logic [WIDTH-1:0]  ReadDataA;
  logic [WIDTH-1:0]  ReadDataB;
  logic              SelectError;

  modport master (
    output WriteEnable, WriteSelect, WriteData, ReadAddrA, ReadAddrB,
    input  ReadDataA, ReadDataB, SelectError
  );

  modport slave (
    input  WriteEnable, WriteSelect, WriteData, ReadAddrA, ReadAddrB,
    output ReadDataA, ReadDataB, SelectError
  );

endinterface

// File: rtl/register_bank_16_cell.sv
// Single WIDTH-bit storage cell with load enable and asynchronous clear.
module register_cell #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_bank_16.sv
// Sixteen-entry register bank fed by a one-hot write select, with two
// combinational read ports, optional write-through bypass and a sticky select error.
module register_bank_16
  import regbank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  register_bank_16_if.slave bus
);

  logic                             w_sel_valid;
  wsel_t                            w_load;
  logic [NUM_REGS-1:0][WIDTH-1:0]   w_q;
  logic                             w_byp_a;
  logic                             w_byp_b;
  logic                             r_select_error;

  assign w_sel_valid = onehot16_valid(bus.WriteSelect);

  // w_load doubles as the bypass match vector, so register 0 is masked here once.
  always_comb begin
    w_load = '0;
    if (bus.WriteEnable && w_sel_valid) begin
      w_load = bus.WriteSelect;
    end
    if (ZERO_R0) begin
      w_load[0] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
    register_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .i_clk  (Clock),
      .i_rst  (Reset),
      .i_load (w_load[gi]),
      .i_d    (bus.WriteData),
      .o_q    (w_q[gi])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_select_error <= 1'b0;
    end else if (bus.WriteEnable && !w_sel_valid) begin
      r_select_error <= 1'b1;
    end
  end

  assign bus.SelectError = r_select_error;

  // Bypass is held off during reset so both ports read zero while storage is cleared.
  assign w_byp_a = BYPASS && !Reset && w_load[bus.ReadAddrA];
  assign w_byp_b = BYPASS && !Reset && w_load[bus.ReadAddrB];

  always_comb begin
    bus.ReadDataA = w_q[bus.ReadAddrA];
    bus.ReadDataB = w_q[bus.ReadAddrB];
    if (ZERO_R0 && (bus.ReadAddrA == '0)) begin
      bus.ReadDataA = '0;
    end
    if (ZERO_R0 && (bus.ReadAddrB == '0)) begin
      bus.ReadDataB = '0;
    end
    if (w_byp_a) begin
      bus.ReadDataA = bus.WriteData;
    end
    if (w_byp_b) begin
      bus.ReadDataB = bus.WriteData;
    end
  end

endmodule

// File: tb/tb_register_bank_16.sv
// Directed bench for register_bank_16: default bank, a no-bypass bank and a
// zero-register bank share one clock and identical stimulus.
module tb_register_bank_16;

  logic Clock;
  logic Reset;

  register_bank_16_if #(.WIDTH(16)) if_d ();
  register_bank_16_if #(.WIDTH(16)) if_n ();
  register_bank_16_if #(.WIDTH(16)) if_z ();

  register_bank_16 #(.WIDTH(16), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_dut (
    .Clock (Clock), .Reset (Reset), .bus (if_d.slave)
  );
  register_bank_16 #(.WIDTH(16), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_nb (
    .Clock (Clock), .Reset (Reset), .bus (if_n.slave)
  );
  register_bank_16 #(.WIDTH(16), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_z0 (
    .Clock (Clock), .Reset (Reset), .bus (if_z.slave)
  );

  int checks;
  int errors;
  logic [15:0] m [16];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [15:0] sel, input logic [15:0] d,
                       input logic [3:0] a, input logic [3:0] b);
    if_d.WriteEnable = we; if_d.WriteSelect = sel; if_d.WriteData = d;
    if_d.ReadAddrA = a; if_d.ReadAddrB = b;
    if_n.WriteEnable = we; if_n.WriteSelect = sel; if_n.WriteData = d;
    if_n.ReadAddrA = a; if_n.ReadAddrB = b;
    if_z.WriteEnable = we; if_z.WriteSelect = sel; if_z.WriteData = d;
    if_z.ReadAddrA = a; if_z.ReadAddrB = b;
  endtask

  // Sweep every address of the default bank against the model; WriteEnable must be low.
  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 16'h0000, 16'h0000, 4'(i), 4'(15 - i));
      #1;
      chk($sformatf("%s_A%0d", tag, i), {16'h0, if_d.ReadDataA}, {16'h0, m[i]});
      chk($sformatf("%s_B%0d", tag, 15 - i), {16'h0, if_d.ReadDataB}, {16'h0, m[15 - i]});
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
  endtask

  task automatic write_cycle(input logic [15:0] sel, input logic [15:0] d,
                             input logic [3:0] a, input logic [3:0] b);
    @(negedge Clock);
    drive(1'b1, sel, d, a, b);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    checks = 0;
    errors = 0;
    clear_model();

    // Reset with random traffic, including a bypass-shaped write and a bad select.
    Reset = 1'b1;
    r = 4'($urandom_range(15));
    drive(1'b1, 16'h0001 << r, 16'($urandom), r, r);
    #1;
    chk("rst_d_A", {16'h0, if_d.ReadDataA}, 32'h0);
    chk("rst_d_B", {16'h0, if_d.ReadDataB}, 32'h0);
    chk("rst_n_A", {16'h0, if_n.ReadDataA}, 32'h0);
    @(posedge Clock); #1;
    chk("rst_d_A_edge", {16'h0, if_d.ReadDataA}, 32'h0);
    chk("rst_z_B_edge", {16'h0, if_z.ReadDataB}, 32'h0);
    @(negedge Clock);
    drive(1'b1, 16'h0030, 16'($urandom), r, r);
    @(posedge Clock); #1;
    chk("rst_err_d", {31'h0, if_d.SelectError}, 32'h0);
    @(negedge Clock);
    drive(1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0);
    Reset = 1'b0;
    #1;
    chk("post_rst_err_d", {31'h0, if_d.SelectError}, 32'h0);
    chk("post_rst_err_z", {31'h0, if_z.SelectError}, 32'h0);
    check_all("post_rst");

    // WriteEnable low with a malformed select: nothing happens.
    @(negedge Clock);
    drive(1'b0, 16'h0030, 16'hABCD, 4'd4, 4'd5);
    @(posedge Clock); #1;
    chk("we0_err_d", {31'h0, if_d.SelectError}, 32'h0);
    chk("we0_err_n", {31'h0, if_n.SelectError}, 32'h0);
    chk("we0_r4", {16'h0, if_d.ReadDataA}, 32'h0);

    // Basic write of register 5, bypass visible only on the bypassing bank.
    @(negedge Clock);
    drive(1'b1, 16'h0020, 16'h1234, 4'd5, 4'd5);
    #1;
    chk("wr5_byp_d_A", {16'h0, if_d.ReadDataA}, 32'h1234);
    chk("wr5_byp_n_A", {16'h0, if_n.ReadDataA}, 32'h0);
    @(posedge Clock); #1;
    chk("wr5_n_A", {16'h0, if_n.ReadDataA}, 32'h1234);
    chk("wr5_n_B", {16'h0, if_n.ReadDataB}, 32'h1234);
    chk("wr5_z_A", {16'h0, if_z.ReadDataA}, 32'h1234);
    m[5] = 16'h1234;
    @(negedge Clock);
    check_all("wr5");

    // Bypass of register 9 while port B reads an untouched-by-write register.
    @(negedge Clock);
    drive(1'b1, 16'h0200, 16'hBEEF, 4'd9, 4'd5);
    #1;
    chk("byp9_d_A", {16'h0, if_d.ReadDataA}, 32'hBEEF);
    chk("byp9_d_B", {16'h0, if_d.ReadDataB}, 32'h1234);
    chk("byp9_n_A_old", {16'h0, if_n.ReadDataA}, 32'h0);
    @(posedge Clock); #1;
    chk("byp9_n_A_new", {16'h0, if_n.ReadDataA}, 32'hBEEF);
    m[9] = 16'hBEEF;

    // Back-to-back writes to one register: last one wins.
    write_cycle(16'h0200, 16'h1111, 4'd9, 4'd9);
    write_cycle(16'h0200, 16'h2222, 4'd9, 4'd9);
    @(negedge Clock);
    drive(1'b0, 16'h0000, 16'h0000, 4'd9, 4'd9);
    #1;
    chk("b2b_d", {16'h0, if_d.ReadDataA}, 32'h2222);
    chk("b2b_n", {16'h0, if_n.ReadDataB}, 32'h2222);
    m[9] = 16'h2222;

    // Register 0 write: lands normally, dropped silently on the zero-register bank.
    @(negedge Clock);
    drive(1'b1, 16'h0001, 16'hFFFF, 4'd0, 4'd0);
    #1;
    chk("r0_byp_d", {16'h0, if_d.ReadDataA}, 32'hFFFF);
    chk("r0_byp_z", {16'h0, if_z.ReadDataA}, 32'h0);
    @(posedge Clock); #1;
    chk("r0_z_A", {16'h0, if_z.ReadDataA}, 32'h0);
    chk("r0_z_err", {31'h0, if_z.SelectError}, 32'h0);
    chk("r0_d_A", {16'h0, if_d.ReadDataA}, 32'hFFFF);
    m[0] = 16'hFFFF;

    // Two-hot select: no bypass, no store, error only after the edge, then sticky.
    @(negedge Clock);
    drive(1'b1, 16'h0030, 16'hDEAD, 4'd4, 4'd5);
    #1;
    chk("bad30_err_pre", {31'h0, if_d.SelectError}, 32'h0);
    chk("bad30_A_nobyp", {16'h0, if_d.ReadDataA}, 32'h0);
    chk("bad30_B_nobyp", {16'h0, if_d.ReadDataB}, 32'h1234);
    @(posedge Clock); #1;
    chk("bad30_err_d", {31'h0, if_d.SelectError}, 32'h1);
    chk("bad30_err_z", {31'h0, if_z.SelectError}, 32'h1);
    write_cycle(16'h0004, 16'h0002, 4'd2, 4'd2);
    m[2] = 16'h0002;
    chk("bad30_sticky", {31'h0, if_d.SelectError}, 32'h1);
    @(negedge Clock);
    check_all("bad30");

    // Zero-hot select after a fresh reset.
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    clear_model();
    chk("rst2_err", {31'h0, if_d.SelectError}, 32'h0);
    @(negedge Clock);
    drive(1'b1, 16'h0000, 16'h7777, 4'd0, 4'd1);
    @(posedge Clock); #1;
    chk("bad00_err", {31'h0, if_d.SelectError}, 32'h1);
    chk("bad00_err_n", {31'h0, if_n.SelectError}, 32'h1);
    @(negedge Clock);
    check_all("bad00");

    // Fill all registers, then reset asynchronously in the middle of a write to r3.
    for (int i = 0; i < 16; i++) begin
      m[i] = 16'hA000 + 16'(i) * 16'h0101;
      write_cycle(16'h0001 << i, m[i], 4'd0, 4'd0);
    end
    @(negedge Clock);
    check_all("fill");
    @(negedge Clock);
    drive(1'b1, 16'h0008, 16'h5555, 4'd3, 4'd7);
    #1;
    chk("mid_byp_A", {16'h0, if_d.ReadDataA}, 32'h5555);
    chk("mid_B", {16'h0, if_d.ReadDataB}, 32'hA707);
    #1;
    Reset = 1'b1;
    #1;
    chk("mid_rst_A", {16'h0, if_d.ReadDataA}, 32'h0);
    chk("mid_rst_B", {16'h0, if_d.ReadDataB}, 32'h0);
    chk("mid_rst_n_B", {16'h0, if_n.ReadDataB}, 32'h0);
    @(posedge Clock); #1;
    chk("mid_rst_edge_A", {16'h0, if_d.ReadDataA}, 32'h0);
    @(negedge Clock);
    drive(1'b0, 16'h0000, 16'h0000, 4'd3, 4'd3);
    Reset = 1'b0;
    clear_model();
    @(posedge Clock); #1;
    chk("mid_r3_after", {16'h0, if_d.ReadDataA}, 32'h0);
    @(negedge Clock);
    check_all("mid_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
